// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: instruction fetch sequencer for a byte-wide, big-endian,
// 1-cycle-latency synchronous instruction memory.
// - Issues four byte reads per instruction.
// - Assembles the 32-bit word, most significant byte at the lowest address.
// - Hands the word to decode over a valid/ready handshake.
// - Owns the PC and applies redirects (pc_load) and halt.
// Optional build macro FETCH_STATS_EN adds fetch_count / redirect_count outputs.
module instr_fetch_ctrl #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              halt,
  input  logic              pc_load,
  input  logic [31:0]       pc_target,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [31:0]       instr_pc,
  output logic              busy,
`ifdef FETCH_STATS_EN
  output logic [31:0]       fetch_count,
  output logic [15:0]       redirect_count,
`endif
  output logic              align_err
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [2:0]  issue_cnt;  // 0..3 = reads still to issue, 4 = all issued
  logic [1:0]  cap_cnt;    // which byte lane the next returned byte fills
  logic        cap_en;     // a byte for the current fetch arrives this cycle
  logic        xfer;
  logic        last_cap;

  assign xfer     = instr_valid && instr_ready;
  assign last_cap = cap_en && (cap_cnt == 2'd3);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and memory request outputs.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_nxt = state;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    busy      = 1'b0;
    unique case (state)
      IDLE: if (!halt) state_nxt = FETCH;
      FETCH: begin
        busy = 1'b1;
        if (!issue_cnt[2]) begin
          mem_rd_en = 1'b1;
          mem_addr  = pc[ADDR_W-1:0] + ADDR_W'(issue_cnt[1:0]);
        end
        if (last_cap) state_nxt = HOLD;
      end
      HOLD: if (xfer) state_nxt = halt ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
    // A redirect restarts from any state; halt only decides whether it waits.
    if (pc_load) state_nxt = halt ? IDLE : FETCH;
  end

  // PC, issue/capture counters, word assembly and handshake register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the assembled word and its PC are reset too, because they are
    // visible outputs that must read 0 while in reset.
    if (!rst_n) begin
      pc          <= RESET_PC;
      issue_cnt   <= '0;
      cap_cnt     <= '0;
      cap_en      <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      align_err   <= 1'b0;
    end else begin
      align_err <= pc_load && (pc_target[1:0] != 2'b00);
      // A byte requested in the redirect cycle belongs to the aborted fetch.
      cap_en    <= mem_rd_en && !pc_load;
      if (pc_load) begin
        pc          <= {pc_target[31:2], 2'b00};
        issue_cnt   <= '0;
        cap_cnt     <= '0;
        instr_valid <= 1'b0;
      end else begin
        if (mem_rd_en) issue_cnt <= issue_cnt + 3'd1;
        if (cap_en) begin
          unique case (cap_cnt)
            2'd0: instr[31:24] <= mem_rdata;
            2'd1: instr[23:16] <= mem_rdata;
            2'd2: instr[15:8]  <= mem_rdata;
            2'd3: instr[7:0]   <= mem_rdata;
            default: ;
          endcase
          cap_cnt <= cap_cnt + 2'd1;
          if (last_cap) begin
            instr_valid <= 1'b1;
            instr_pc    <= pc;
            issue_cnt   <= '0;
          end
        end
        if (xfer) begin
          instr_valid <= 1'b0;
          pc          <= pc + 32'd4;
        end
      end
    end
  end

`ifdef FETCH_STATS_EN
  // Transfer and redirect statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count    <= '0;
      redirect_count <= '0;
    end else begin
      if (xfer) fetch_count <= fetch_count + 32'd1;
      if (pc_load && (redirect_count != 16'hFFFF))
        redirect_count <= redirect_count + 16'd1;
    end
  end
`endif

endmodule
